// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath,
// READ/WRITE per neuron, spike FIFO. Optional refractory flags under LIF_REFRACTORY_EN.
module lif_scheduler #(
    parameter int unsigned N_NEURONS  = 4,
    parameter int unsigned THRESHOLD  = 200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step_start,
    input  logic [8*N_NEURONS-1:0]       cur_flat,
    output logic                         busy,
    output logic                         done,
    output logic                         spk_valid,
    output logic [$clog2(N_NEURONS)-1:0] spk_idx,
    input  logic                         spk_ready,
    output logic                         ovf,
    input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
    output logic [7:0]                   rd_state
);

    localparam int unsigned IW = $clog2(N_NEURONS);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e          fsm_q, fsm_d;
    logic [IW-1:0]   nidx_q, nidx_d;
    logic [7:0]      neur_q [N_NEURONS];
    logic [7:0]      neur_d [N_NEURONS];
    logic [7:0]      pst_q, pst_d;
    logic [7:0]      pcur_q, pcur_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      rd_state_q, rd_state_d;

    logic [IW-1:0]   fifo_q [FIFO_DEPTH];
    logic [IW-1:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            spk_valid_q, spk_valid_d;
    logic [IW-1:0]   spk_idx_q, spk_idx_d;
    logic            ovf_q, ovf_d;

    logic [7:0]      cur_arr [N_NEURONS];
    logic [8:0]      sum;
    logic            push;
    logic            pop;
    logic            full;
    logic            refr_c;

`ifdef LIF_REFRACTORY_EN
    logic [N_NEURONS-1:0] refr_q, refr_d;
    assign refr_c = refr_q[nidx_q];
`else
    assign refr_c = 1'b0;
`endif

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cur
        assign cur_arr[g] = cur_flat[8*g +: 8];
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Sequencer and membrane update: READ latches operands, WRITE commits one neuron.
    always_comb begin
        fsm_d      = fsm_q;
        nidx_d     = nidx_q;
        neur_d     = neur_q;
        pst_d      = pst_q;
        pcur_d     = pcur_q;
        done_d     = 1'b0;
        push       = 1'b0;
        sum        = 9'(pst_q >> 1) + 9'(pcur_q);
`ifdef LIF_REFRACTORY_EN
        refr_d     = refr_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (step_start) begin
                    fsm_d  = READ;
                    nidx_d = '0;
                end
            end
            READ: begin
                pst_d  = neur_q[nidx_q];
                pcur_d = cur_arr[nidx_q];
                fsm_d  = WRITE;
            end
            WRITE: begin
                if (refr_c) begin
                    neur_d[nidx_q] = '0;
                end else if (sum >= 9'(THRESHOLD)) begin
                    neur_d[nidx_q] = '0;
                    push           = 1'b1;
                end else begin
                    neur_d[nidx_q] = sum[7:0];
                end
`ifdef LIF_REFRACTORY_EN
                refr_d[nidx_q] = push;
`endif
                if (nidx_q == IW'(N_NEURONS - 1)) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end else begin
                    fsm_d  = READ;
                    nidx_d = nidx_q + IW'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
        busy_d     = (fsm_d != IDLE);
        rd_state_d = neur_q[rd_idx];
    end

    // Spike FIFO; a push into a full FIFO survives only when the head leaves the same cycle.
    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        pop    = spk_valid_q && spk_ready;
        full   = (cnt_q == CW'(FIFO_DEPTH));
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
            cnt_d  = cnt_d - CW'(1);
        end
        if (push) begin
            if (!full || pop) begin
                fifo_d[wptr_q] = nidx_q;
                wptr_d         = ptr_inc(wptr_q);
                cnt_d          = cnt_d + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        spk_valid_d = (cnt_d != '0);
        spk_idx_d   = fifo_d[rptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            nidx_q      <= '0;
            neur_q      <= '{default: '0};
            pst_q       <= '0;
            pcur_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_state_q  <= '0;
            fifo_q      <= '{default: '0};
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            ovf_q       <= 1'b0;
`ifdef LIF_REFRACTORY_EN
            refr_q      <= '0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            nidx_q      <= nidx_d;
            neur_q      <= neur_d;
            pst_q       <= pst_d;
            pcur_q      <= pcur_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_state_q  <= rd_state_d;
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            ovf_q       <= ovf_d;
`ifdef LIF_REFRACTORY_EN
            refr_q      <= refr_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign spk_valid = spk_valid_q;
    assign spk_idx   = spk_idx_q;
    assign ovf       = ovf_q;
    assign rd_state  = rd_state_q;

endmodule
